// File: rtl/sprite_compositor_avl_if.sv
// Avalon-MM slave bundle for the sprite compositor descriptor/control registers.
interface sprite_compositor_avl_if;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [3:0]  AVL_BYTE_EN;
    logic [4:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
                    input  AVL_READDATA);
    modport slave  (input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
                    output AVL_READDATA);
endinterface

// File: rtl/sprite_compositor_avl.sv
// Double-buffered sprite descriptor bank with a 3-cycle pixel pipeline driving a sprite-sheet ROM.
// Define SPRITE_HFLIP_EN to make descriptor bit 10 mirror the sprite horizontally.
module sprite_compositor_avl #(
    parameter int SPRITE_NUM = 8,
    parameter int SPRITE_W   = 30,
    parameter int SPRITE_H   = 50,
    parameter int SHEET_COLS = 10,
    parameter int POSE_MAX   = 80,
    parameter int SHEET_W    = 300,
    parameter int ROM_AW     = 16,
    parameter int TRANSP_IDX = 0,
    parameter int BG_IDX     = 0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    sprite_compositor_avl_if.slave avl,
    input  logic [9:0]             drawx,
    input  logic [9:0]             drawy,
    input  logic                   frame_start,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [7:0]             rom_data,
    output logic [7:0]             color_index,
    output logic [1:0]             game_status
);
    localparam int         IW        = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1;
    localparam logic [4:0] CTRL_ADDR = 5'd16;

    logic [31:0] r_pend     [SPRITE_NUM];
    logic [9:0]  r_act_x    [SPRITE_NUM];
    logic [9:0]  r_act_y    [SPRITE_NUM];
    logic        r_act_en   [SPRITE_NUM];
    logic [6:0]  r_act_pose [SPRITE_NUM];
`ifdef SPRITE_HFLIP_EN
    logic        r_act_flip [SPRITE_NUM];
`endif
    logic [2:0]            r_ctrl;
    logic [SPRITE_NUM-1:0] r_hit_vec;
    logic [9:0]            r_px;
    logic [9:0]            r_py;
    logic                  r_hit_s2;
    logic                  r_hit_s3;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_desc_sel;
    logic                  w_commit;
    logic [2:0]            w_ctrl_next;
    logic [SPRITE_NUM-1:0] w_hit_vec;
    logic [IW-1:0]         w_sel;
    logic                  w_any;
    logic [31:0]           w_pose;
    logic [31:0]           w_dx;
    logic [31:0]           w_dy;
    logic [ROM_AW-1:0]     w_addr;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

    assign w_wr        = avl.AVL_CS & avl.AVL_WRITE;
    assign w_rd        = avl.AVL_CS & avl.AVL_READ;
    assign w_desc_sel  = 32'(avl.AVL_ADDR) < SPRITE_NUM;
    assign w_commit    = frame_start & r_ctrl[2];
    assign game_status = r_ctrl[1:0];

    // A control write landing on a commit frame wins, so a commit set then waits for the next frame.
    always_comb begin
        w_ctrl_next = r_ctrl;
        if (w_commit) w_ctrl_next[2] = 1'b0;
        if (w_wr && avl.AVL_ADDR == CTRL_ADDR && avl.AVL_BYTE_EN[0])
            w_ctrl_next = avl.AVL_WRITEDATA[2:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ctrl <= '0;
            for (int i = 0; i < SPRITE_NUM; i++) begin
                r_pend[i]     <= '0;
                r_act_x[i]    <= '0;
                r_act_y[i]    <= '0;
                r_act_en[i]   <= 1'b0;
                r_act_pose[i] <= '0;
`ifdef SPRITE_HFLIP_EN
                r_act_flip[i] <= 1'b0;
`endif
            end
        end else begin
            r_ctrl <= w_ctrl_next;
            for (int i = 0; i < SPRITE_NUM; i++) begin
                if (w_wr && avl.AVL_ADDR == 5'(i))
                    r_pend[i] <= f_merge(r_pend[i], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
                if (w_commit) begin
                    r_act_x[i]    <= r_pend[i][31:22];
                    r_act_y[i]    <= r_pend[i][21:12];
                    r_act_en[i]   <= r_pend[i][11];
                    r_act_pose[i] <= r_pend[i][6:0];
`ifdef SPRITE_HFLIP_EN
                    r_act_flip[i] <= r_pend[i][10];
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            avl.AVL_READDATA <= '0;
        else if (w_rd) begin
            if (w_desc_sel)                      avl.AVL_READDATA <= r_pend[avl.AVL_ADDR[IW-1:0]];
            else if (avl.AVL_ADDR == CTRL_ADDR)  avl.AVL_READDATA <= {29'd0, r_ctrl};
            else                                 avl.AVL_READDATA <= '0;
        end
    end

    // 11-bit compares so a sprite near x=1023 does not wrap to the left edge.
    always_comb begin
        w_hit_vec = '0;
        for (int i = 0; i < SPRITE_NUM; i++)
            w_hit_vec[i] = r_act_en[i] && ({1'b0, r_act_pose[i]} < 8'(POSE_MAX))
                        && ({1'b0, drawx} >= {1'b0, r_act_x[i]})
                        && ({1'b0, drawx} <  {1'b0, r_act_x[i]} + 11'(SPRITE_W))
                        && ({1'b0, drawy} >= {1'b0, r_act_y[i]})
                        && ({1'b0, drawy} <  {1'b0, r_act_y[i]} + 11'(SPRITE_H));
    end

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = SPRITE_NUM - 1; i >= 0; i--) begin
            if (r_hit_vec[i]) begin
                w_sel = IW'(i);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_pose = 32'(r_act_pose[w_sel]);
        w_dx   = 32'(r_px - r_act_x[w_sel]);
        w_dy   = 32'(r_py - r_act_y[w_sel]);
`ifdef SPRITE_HFLIP_EN
        if (r_act_flip[w_sel]) w_dx = 32'(SPRITE_W - 1) - w_dx;
`endif
        w_addr = ROM_AW'(((w_pose / SHEET_COLS) * SPRITE_H + w_dy) * SHEET_W
                         + (w_pose % SHEET_COLS) * SPRITE_W + w_dx);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hit_vec   <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_hit_s2    <= 1'b0;
            r_hit_s3    <= 1'b0;
            rom_addr    <= '0;
            color_index <= 8'(BG_IDX);
        end else begin
            r_hit_vec   <= w_hit_vec;
            r_px        <= drawx;
            r_py        <= drawy;
            r_hit_s2    <= w_any;
            rom_addr    <= w_any ? w_addr : '0;
            r_hit_s3    <= r_hit_s2;
            color_index <= (r_hit_s3 && rom_data != 8'(TRANSP_IDX)) ? rom_data : 8'(BG_IDX);
        end
    end
endmodule

// File: tb/tb_sprite_compositor_avl.sv
// Randomised and directed bench for sprite_compositor_avl against a per-pixel scene model.
module tb_sprite_compositor_avl;
    localparam int SN = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  drawx, drawy;
    logic        frame_start;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  color_index;
    logic [1:0]  game_status;

    sprite_compositor_avl_if avl_if_i ();

    sprite_compositor_avl dut (
        .CLK(CLK), .RESET(RESET), .avl(avl_if_i),
        .drawx(drawx), .drawy(drawy), .frame_start(frame_start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .color_index(color_index), .game_status(game_status)
    );

    always #10 CLK = ~CLK;

    logic [7:0] rom_mem [65536];
    always @(posedge CLK) rom_data <= rom_mem[rom_addr];

    logic [31:0] m_pend [SN];
    logic [31:0] m_act  [SN];
    logic [2:0]  m_ctrl;
    logic [31:0] m_rd;
    int          px_q[$], py_q[$];
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] desc(input int x, input int y, input int en, input int fl, input int pose);
        return (32'(x) << 22) | (32'(y) << 12) | (32'(en & 1) << 11) | (32'(fl & 1) << 10) | 32'(pose & 127);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < SN; i++) begin m_pend[i] = 0; m_act[i] = 0; end
        m_ctrl = 0;
        m_rd   = 0;
    endfunction

    // The scene as the display sees it: first enabled, valid, covering sprite wins.
    function automatic void m_pixel(input int px, input int py, output int ea, output int ec);
        int x, y, pose, dx, dy;
        bit en, fl, found;
        ea = 0; ec = 0; found = 0;
        for (int i = 0; i < SN && !found; i++) begin
            x = int'(m_act[i][31:22]); y = int'(m_act[i][21:12]);
            en = m_act[i][11]; fl = m_act[i][10]; pose = int'(m_act[i][6:0]);
            if (en && pose < 80 && px >= x && px < x + 30 && py >= y && py < y + 50) begin
                found = 1;
                dx = px - x; dy = py - y;
`ifdef SPRITE_HFLIP_EN
                if (fl) dx = 29 - dx;
`endif
                ea = (((pose / 10) * 50 + dy) * 300 + (pose % 10) * 30 + dx) & 16'hFFFF;
                ec = int'(rom_mem[ea]);
            end
        end
    endfunction

    task automatic bus(input bit wr, input bit rd, input bit fs, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        avl_if_i.AVL_CS = wr | rd; avl_if_i.AVL_WRITE = wr; avl_if_i.AVL_READ = rd;
        avl_if_i.AVL_ADDR = a; avl_if_i.AVL_WRITEDATA = d; avl_if_i.AVL_BYTE_EN = be;
        frame_start = fs;
        @(negedge CLK);
        avl_if_i.AVL_CS = 0; avl_if_i.AVL_WRITE = 0; avl_if_i.AVL_READ = 0;
        avl_if_i.AVL_BYTE_EN = 0; frame_start = 0;
        if (rd) m_rd = (a < SN) ? m_pend[a] : (a == 16) ? {29'd0, m_ctrl} : 32'd0;
        if (fs && m_ctrl[2]) begin
            for (int i = 0; i < SN; i++) m_act[i] = m_pend[i];
            m_ctrl[2] = 0;
        end
        if (wr) begin
            if (a < SN) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_pend[a][8*b +: 8] = d[8*b +: 8];
            end else if (a == 16 && be[0]) m_ctrl = d[2:0];
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1, 0, 0, a, d, be);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a);
        bus(0, 1, 0, a, 0, 0);
        chk(tag, avl_if_i.AVL_READDATA, m_rd);
    endtask

    task automatic frame();
        bus(0, 0, 1, 0, 0, 0);
    endtask

    task automatic pix1(input string tag, input int x, input int y, input logic [15:0] ea, input logic [7:0] ec);
        drawx = 10'(x); drawy = 10'(y);
        @(negedge CLK);
        drawx = 0; drawy = 0;
        @(negedge CLK);
        chk({tag, "_addr"}, 32'(rom_addr), 32'(ea));
        repeat (2) @(negedge CLK);
        chk({tag, "_col"}, 32'(color_index), 32'(ec));
    endtask

    task automatic run_pixels(input string tag);
        int n, ea, ec;
        int eaq[$], ecq[$];
        n = px_q.size();
        for (int i = 0; i < n; i++) begin
            m_pixel(px_q[i], py_q[i], ea, ec);
            eaq.push_back(ea); ecq.push_back(ec);
        end
        for (int t = 0; t < n + 4; t++) begin
            if (t >= 2) chk({tag, "_addr"}, 32'(rom_addr), 32'(eaq[t-2]));
            if (t >= 4) chk({tag, "_col"}, 32'(color_index), 32'(ecq[t-4]));
            if (t < n) begin drawx = 10'(px_q[t]); drawy = 10'(py_q[t]); end
            else begin drawx = 0; drawy = 0; end
            @(negedge CLK);
        end
        px_q.delete(); py_q.delete();
    endtask

    initial begin
        RESET = 1; drawx = 0; drawy = 0; frame_start = 0;
        avl_if_i.AVL_CS = 0; avl_if_i.AVL_READ = 0; avl_if_i.AVL_WRITE = 0;
        avl_if_i.AVL_ADDR = 0; avl_if_i.AVL_WRITEDATA = 0; avl_if_i.AVL_BYTE_EN = 0;
        for (int i = 0; i < 65536; i++) rom_mem[i] = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
        rom_mem[90] = 8'h5A;    rom_mem[119] = 8'h00;   rom_mem[14819] = 8'h66;
        rom_mem[3100] = 8'h31;  rom_mem[16565] = 8'h77; rom_mem[13] = 8'h13;
        rom_mem[14713] = 8'h47; rom_mem[150] = 8'h15;   rom_mem[3040] = 8'h99;
        m_reset();
        repeat (3) @(negedge CLK);
        chk("rst_rd", avl_if_i.AVL_READDATA, 0);
        chk("rst_rom", 32'(rom_addr), 0);
        chk("rst_col", 32'(color_index), 0);
        chk("rst_gs", 32'(game_status), 0);
        RESET = 0;
        rd_chk("rst_pend0", 0);

        // sprite 0 at (200,100) pose 3; nothing shows until the commit frame
        wr(0, desc(200, 100, 1, 0, 3), 4'hF);
        wr(16, 32'h5, 4'hF);
        chk("gs1", 32'(game_status), 32'(m_ctrl[1:0]));
        pix1("pre_commit", 200, 100, 0, 0);
        frame();
        pix1("basic", 200, 100, 16'd90, 8'h5A);
        rd_chk("ctrl_cleared", 16);

        wr(1, desc(205, 105, 1, 0, 12), 4'hF);
        wr(16, 32'h4, 4'hF);
        frame();
        pix1("prio", 210, 110, 16'd3100, 8'h31);
        wr(0, 32'h0, 4'b0010);
        wr(16, 32'h4, 4'hF);
        frame();
        pix1("prio_dis", 210, 110, 16'd16565, 8'h77);

        wr(0, desc(200, 100, 1, 0, 3), 4'hF);
        wr(1, desc(600, 100, 1, 0, 12), 4'hF);
        wr(2, desc(1010, 0, 1, 0, 0), 4'hF);
        wr(3, desc(500, 300, 1, 0, 80), 4'hF);
        wr(16, 32'h4, 4'hF);
        frame();
        pix1("edge_transp", 229, 100, 16'd119, 8'h00);
        pix1("edge_in", 229, 149, 16'd14819, 8'h66);
        pix1("edge_out", 230, 100, 0, 0);
        pix1("edge_ybot", 200, 150, 0, 0);
        pix1("x1023", 1023, 0, 16'd13, 8'h13);
        pix1("x1023_y49", 1023, 49, 16'd14713, 8'h47);
        pix1("nowrap", 5, 10, 0, 0);
        pix1("pose80", 510, 310, 0, 0);

        wr(5, 32'hAABBCCDD, 4'hF);
        wr(5, 32'h11223344, 4'b0100);
        rd_chk("be0100", 5);
        chk("be0100_val", avl_if_i.AVL_READDATA, 32'hAA22CCDD);
        wr(5, 32'hFFFFFFFF, 4'b0000);
        rd_chk("be0000", 5);
        chk("be0000_val", avl_if_i.AVL_READDATA, 32'hAA22CCDD);
        @(negedge CLK);
        chk("rd_hold", avl_if_i.AVL_READDATA, m_rd);
        wr(20, 32'h12345678, 4'hF);
        rd_chk("unmapped", 20);
        rd_chk("ctrl_rd", 16);

        // commit boundary cases around frame_start
        wr(0, desc(700, 400, 1, 0, 5), 4'hF);
        frame();
        pix1("nocommit", 229, 149, 16'd14819, 8'h66);
        bus(1, 0, 1, 16, 32'h4, 4'hF);
        pix1("coinc_commit", 229, 149, 16'd14819, 8'h66);
        frame();
        pix1("second_frame_old", 229, 149, 0, 0);
        pix1("second_frame_new", 700, 400, 16'd150, 8'h15);
        wr(16, 32'h4, 4'hF);
        bus(1, 0, 1, 0, desc(200, 100, 1, 0, 3), 4'hF);
        pix1("coinc_write_excl", 700, 400, 16'd150, 8'h15);
        frame();
        pix1("no_recommit", 700, 400, 16'd150, 8'h15);
        wr(16, 32'h4, 4'hF);
        frame();
        pix1("late_write", 200, 100, 16'd90, 8'h5A);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < SN; i++)
                wr(5'(i), desc(300 + int'($urandom % 40), 200 + int'($urandom % 40),
                               int'($urandom % 4 != 0), int'($urandom % 2), int'($urandom % 90))
                          | (32'($urandom) & 32'h0000_0380), 4'hF);
            wr(16, 32'h4 | 32'($urandom % 4), 4'hF);
            frame();
            chk("rand_gs", 32'(game_status), 32'(m_ctrl[1:0]));
            for (int p = 0; p < 150; p++) begin
                px_q.push_back(295 + int'($urandom % 90));
                py_q.push_back(195 + int'($urandom % 100));
            end
            run_pixels("rand");
        end

        // reset in the middle of a stream of hitting pixels
        wr(0, desc(100, 100, 1, 0, 1), 4'hF);
        wr(16, 32'h7, 4'hF);
        frame();
        rd_chk("pre_rst_ctrl", 16);
        drawx = 110; drawy = 110;
        repeat (4) @(negedge CLK);
        chk("pre_rst_col", 32'(color_index), 32'h99);
        RESET = 1;
        @(negedge CLK);
        chk("mid_rst_col", 32'(color_index), 0);
        chk("mid_rst_rom", 32'(rom_addr), 0);
        chk("mid_rst_rd", avl_if_i.AVL_READDATA, 0);
        chk("mid_rst_gs", 32'(game_status), 0);
        @(negedge CLK);
        RESET = 0;
        m_reset();
        for (int p = 0; p < 6; p++) begin px_q.push_back(110); py_q.push_back(110); end
        run_pixels("post_rst");
        rd_chk("post_rst_pend0", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
